// File: rtl/router_inject_ni_pkg.sv
// Shared definitions for the router injection network interface:
// flit field layout, entry width, FSM state encoding and a flit builder.
package router_inject_ni_pkg;

  localparam int unsigned FLIT_W      = 32;
  localparam int unsigned VALID_BIT   = 31;
  localparam int unsigned DST_MSB     = 30;
  localparam int unsigned DST_LSB     = 27;
  localparam int unsigned SRC_MSB     = 26;
  localparam int unsigned SRC_LSB     = 23;
  localparam int unsigned AGE_MSB     = 22;
  localparam int unsigned AGE_LSB     = 16;
  localparam int unsigned PAYLOAD_MSB = 15;
  localparam int unsigned PAYLOAD_LSB = 0;

  localparam int unsigned DST_W     = DST_MSB - DST_LSB + 1;
  localparam int unsigned SRC_W     = SRC_MSB - SRC_LSB + 1;
  localparam int unsigned AGE_W     = AGE_MSB - AGE_LSB + 1;
  localparam int unsigned PAYLOAD_W = PAYLOAD_MSB - PAYLOAD_LSB + 1;
  localparam int unsigned ENTRY_W   = DST_W + PAYLOAD_W;
  localparam int unsigned AGE_MAX   = (1 << AGE_W) - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } ni_state_e;

  // Assemble a valid flit from its fields.
  function automatic logic [FLIT_W-1:0] make_flit(
    input logic [DST_W-1:0]     dst,
    input logic [SRC_W-1:0]     src,
    input logic [AGE_W-1:0]     age,
    input logic [PAYLOAD_W-1:0] payload
  );
    return {1'b1, dst, src, age, payload};
  endfunction

endpackage

// File: rtl/router_inject_ni_fifo.sv
// Synchronous FIFO holding {dst,payload} entries for the injection NI.
// Ports: clk, rst_n (sync active-low), i_push/i_din write at tail,
// i_pop removes head, o_dout = head entry, o_full/o_empty/o_count status.
// Push while full and pop while empty are ignored.
module ni_fifo
  import router_inject_ni_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/router_inject_ni.sv
// Core-side injection network interface for the deflection router.
// Ports: clk, rst_n (sync active-low); core_valid/core_ready/core_dst/
// core_payload core handshake; inject_flit/inj_bit request to the router,
// injection_status same-cycle grant; fifo_count occupancy, starve_flag
// head waited >= STARVE_LIMIT cycles, tx_count granted flits (wraps).
module router_inject_ni
  import router_inject_ni_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SRC_ID       = 0,
  parameter int unsigned STARVE_LIMIT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_valid,
  output logic                   core_ready,
  input  logic [3:0]             core_dst,
  input  logic [15:0]            core_payload,
  output logic [31:0]            inject_flit,
  output logic                   inj_bit,
  input  logic                   injection_status,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   starve_flag,
  output logic [15:0]            tx_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ni_state_e          r_state;
  ni_state_e          w_state_nxt;
  logic [AGE_W-1:0]   r_wait;
  logic [AGE_W-1:0]   w_wait_nxt;
  logic               r_starve;
  logic [15:0]        r_tx;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;

  // core_ready comes only from FIFO state, never from the grant input.
  assign core_ready  = !w_full;
  assign inj_bit     = !w_empty;
  assign w_push      = core_valid && !w_full;
  assign w_pop       = inj_bit && injection_status;
  assign fifo_count  = w_count;
  assign starve_flag = r_starve;
  assign tx_count    = r_tx;

  // Age always tracks the live wait counter so oldest-first arbitration sees it.
  assign inject_flit = inj_bit
                     ? make_flit(w_head[ENTRY_W-1:PAYLOAD_W], SRC_W'(SRC_ID),
                                 r_wait, w_head[PAYLOAD_W-1:0])
                     : '0;

  ni_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({core_dst, core_payload}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next state and next wait count.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      ST_IDLE: begin
        if (w_push) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (w_pop) begin
          w_wait_nxt = '0;
          if (w_count == CNT_W'(1) && !w_push) w_state_nxt = ST_IDLE;
        end else if (r_wait != AGE_W'(AGE_MAX)) begin
          w_wait_nxt = r_wait + AGE_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, wait counter, starvation flag and transmit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wait   <= '0;
      r_starve <= 1'b0;
      r_tx     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wait   <= w_wait_nxt;
      r_starve <= (32'(w_wait_nxt) >= STARVE_LIMIT);
      if (w_pop) r_tx <= r_tx + 16'd1;
    end
  end

endmodule

// File: tb/tb_router_inject_ni.sv
// Self-checking bench for router_inject_ni: directed test-plan sequences
// followed by randomized traffic, checked against a queue-based model.
module tb_router_inject_ni;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned SRC_ID       = 0;
  localparam int unsigned STARVE_LIMIT = 32;

  logic        clk;
  logic        rst_n;
  logic        core_valid;
  logic        core_ready;
  logic [3:0]  core_dst;
  logic [15:0] core_payload;
  logic [31:0] inject_flit;
  logic        inj_bit;
  logic        injection_status;
  logic [2:0]  fifo_count;
  logic        starve_flag;
  logic [15:0] tx_count;

  router_inject_ni #(
    .DEPTH        (DEPTH),
    .SRC_ID       (SRC_ID),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .core_valid       (core_valid),
    .core_ready       (core_ready),
    .core_dst         (core_dst),
    .core_payload     (core_payload),
    .inject_flit      (inject_flit),
    .inj_bit          (inj_bit),
    .injection_status (injection_status),
    .fifo_count       (fifo_count),
    .starve_flag      (starve_flag),
    .tx_count         (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted {dst,payload}, head wait time, grant count.
  logic [19:0] mq[$];
  int          m_wait  = 0;
  int          m_tx    = 0;
  bit          started = 0;
  bit          m_push;
  bit          m_pop;
  logic [31:0] exp_flit;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_wait  = 0;
      m_tx    = 0;
      started = 1;
    end else if (started) begin
      m_push = core_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() > 0) && injection_status;
      if (m_pop) begin
        void'(mq.pop_front());
        m_wait = 0;
        m_tx   = (m_tx + 1) % 65536;
      end else if (mq.size() > 0 && m_wait < 127) begin
        m_wait = m_wait + 1;
      end
      if (m_push) mq.push_back({core_dst, core_payload});
    end
  end

  // Monitor: compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      if (mq.size() == 0) exp_flit = 32'h0;
      else exp_flit = {1'b1, mq[0][19:16], 4'(SRC_ID), 7'(m_wait), mq[0][15:0]};
      check("mon_inj_bit",    {31'd0, inj_bit},     {31'd0, (mq.size() > 0)});
      check("mon_core_ready", {31'd0, core_ready},  {31'd0, (mq.size() < DEPTH)});
      check("mon_fifo_count", {29'd0, fifo_count},  32'(mq.size()));
      check("mon_tx_count",   {16'd0, tx_count},    32'(m_tx));
      check("mon_starve",     {31'd0, starve_flag}, {31'd0, (m_wait >= STARVE_LIMIT)});
      check("mon_flit",       inject_flit,          exp_flit);
      if (inj_bit && injection_status) check("grant_flit", inject_flit, exp_flit);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; core_valid = 1'b0; core_dst = '0; core_payload = '0;
    injection_status = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    check("rst_inj_bit", {31'd0, inj_bit}, 32'd0);
    check("rst_flit", inject_flit, 32'h0);
    check("rst_ready", {31'd0, core_ready}, 32'd1);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_tx", {16'd0, tx_count}, 32'd0);

    // Single packet with grant already high.
    injection_status = 1'b1; core_valid = 1'b1; core_dst = 4'hA; core_payload = 16'h1234;
    cyc(1);
    core_valid = 1'b0;
    check("single_flit", inject_flit, 32'hD0001234);
    check("single_req", {31'd0, inj_bit}, 32'd1);
    cyc(1);
    check("single_done", {31'd0, inj_bit}, 32'd0);
    check("single_tx", {16'd0, tx_count}, 32'd1);

    // Delayed grant: ten ungranted cycles.
    injection_status = 1'b0; core_valid = 1'b1; core_dst = 4'h5; core_payload = 16'hBEEF;
    cyc(1);
    core_valid = 1'b0;
    cyc(10);
    check("delay_age", {25'd0, inject_flit[22:16]}, 32'd10);
    check("delay_hold", {16'd0, inject_flit[15:0]}, 32'h0000BEEF);
    injection_status = 1'b1;
    cyc(1);
    injection_status = 1'b0;
    check("delay_pop", {31'd0, inj_bit}, 32'd0);
    check("delay_tx", {16'd0, tx_count}, 32'd2);

    // Fill and back-pressure.
    core_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_dst = 4'(i); core_payload = 16'h0100 + 16'(i);
      cyc(1);
    end
    core_dst = 4'h4; core_payload = 16'h0104;
    check("fill_ready", {31'd0, core_ready}, 32'd0);
    check("fill_count", {29'd0, fifo_count}, 32'd4);
    cyc(1);
    check("fill_held", {29'd0, fifo_count}, 32'd4);
    check("fill_head", {16'd0, inject_flit[15:0]}, 32'h00000100);
    injection_status = 1'b1;
    cyc(1);
    injection_status = 1'b0;
    check("bp_count", {29'd0, fifo_count}, 32'd3);
    check("bp_ready", {31'd0, core_ready}, 32'd1);
    check("bp_head", {16'd0, inject_flit[15:0]}, 32'h00000101);
    check("bp_age", {25'd0, inject_flit[22:16]}, 32'd0);
    cyc(1);
    core_valid = 1'b0;
    check("bp_refill", {29'd0, fifo_count}, 32'd4);
    injection_status = 1'b1;
    cyc(4);
    injection_status = 1'b0;
    check("drain_count", {29'd0, fifo_count}, 32'd0);
    check("drain_tx", {16'd0, tx_count}, 32'd7);

    // Starvation and age saturation.
    core_valid = 1'b1; core_dst = 4'h3; core_payload = 16'hCAFE;
    cyc(1);
    core_valid = 1'b0;
    cyc(31);
    check("starve_below", {31'd0, starve_flag}, 32'd0);
    cyc(1);
    check("starve_rise", {31'd0, starve_flag}, 32'd1);
    check("starve_age32", {25'd0, inject_flit[22:16]}, 32'd32);
    cyc(95);
    check("age_127", {25'd0, inject_flit[22:16]}, 32'd127);
    cyc(5);
    check("age_sat", {25'd0, inject_flit[22:16]}, 32'd127);
    check("starve_hold", {16'd0, inject_flit[15:0]}, 32'h0000CAFE);
    injection_status = 1'b1;
    cyc(1);
    injection_status = 1'b0;
    check("starve_clear", {31'd0, starve_flag}, 32'd0);
    check("starve_tx", {16'd0, tx_count}, 32'd8);

    // Reset with three entries queued and the request pending.
    core_valid = 1'b1; core_dst = 4'h9; core_payload = 16'h5A5A;
    cyc(3);
    core_valid = 1'b0;
    check("mid_count", {29'd0, fifo_count}, 32'd3);
    rst_n = 1'b0; injection_status = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    check("mid_rst_inj", {31'd0, inj_bit}, 32'd0);
    check("mid_rst_flit", inject_flit, 32'h0);
    check("mid_rst_ready", {31'd0, core_ready}, 32'd1);
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_tx", {16'd0, tx_count}, 32'd0);
    check("mid_rst_starve", {31'd0, starve_flag}, 32'd0);
    cyc(1);
    check("mid_no_pop_tx", {16'd0, tx_count}, 32'd0);
    check("mid_no_pop_inj", {31'd0, inj_bit}, 32'd0);
    injection_status = 1'b0;

    // Randomized traffic with varying grant pressure.
    for (int ph = 0; ph < 6; ph++) begin
      int gp;
      gp = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 40 : 85);
      repeat (500) begin
        core_valid       = ($urandom_range(0, 99) < 60);
        core_dst         = 4'($urandom);
        core_payload     = 16'($urandom);
        injection_status = ($urandom_range(0, 99) < gp);
        cyc(1);
      end
    end
    core_valid = 1'b0; injection_status = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_inject_ni.md
Name: router_inject_ni

Overview:
- Core-side network interface (transmitter) that feeds the injection port of the bufferless deflection router.
- Accepts packets from the local core over a valid/ready handshake and buffers them in a small FIFO.
- Formats each packet as a 32-bit flit and holds it on the router's inject port with a request until the router grants injection.
- Tracks waiting time: stamps it into the flit age field and raises a starvation flag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SRC_ID, 0, 4-bit node id written into every flit.
- STARVE_LIMIT, 32, consecutive ungranted request cycles before starve_flag asserts; range 1..127.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- core_valid  input  1  core presents a packet.
- core_ready  output  1  NI can accept; equals FIFO not full, registered-state only, with no path from injection_status.
- core_dst  input  4  destination id {x[1:0],y[1:0]}.
- core_payload  input  16  packet data.
- inject_flit  output  32  flit to the router's inject port.
- inj_bit  output  1  injection request; high whenever the FIFO is non-empty.
- injection_status  input  1  router grant, combinational in the same cycle.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- starve_flag  output  1  head flit has waited at least STARVE_LIMIT cycles.
- tx_count  output  16  granted flits since reset; wraps at 65535 -> 0.

Behaviour:
- Flit format:
  - [31] valid = 1.
  - [30:27] dst.
  - [26:23] SRC_ID.
  - [22:16] age = head wait counter, saturating at 127.
  - [15:0] payload.
- When the FIFO is empty, inject_flit = 32'h0 and inj_bit = 0.
- Push: on a clock edge with core_valid && core_ready, {dst,payload} is written at the tail.
- Pop: on a clock edge with inj_bit && injection_status, the head is removed.
- Latency: a pushed entry reaches the head no earlier than the next cycle. There is no bypass, so an empty FIFO shows inj_bit at edge+1 after the push.
- Simultaneous push and pop:
  - Occupancy is unchanged, and both pointers advance, wrapping modulo DEPTH.
  - When the FIFO is full, core_ready = 0, so no push occurs even if a pop happens that cycle.
- FSM (2 states):
  - IDLE: FIFO empty. Transitions to REQ when the FIFO becomes non-empty.
  - REQ: inj_bit high. On grant, returns to IDLE if that pop empties the FIFO with no simultaneous push; otherwise stays in REQ with the next head.
- wait_cnt (7-bit):
  - Clears to 0 on every pop.
  - Increments by 1 each REQ cycle without grant, saturating at 127.
  - A newly exposed head starts at 0.
  - The age field always reflects the current wait_cnt, so the router's oldest-first arbitration favours starved flits.
- starve_flag = (wait_cnt >= STARVE_LIMIT), registered. It is cleared together with wait_cnt on grant.
- tx_count increments on each pop.
- Head stability: inject_flit may change only in the age field while no grant is given. dst/src/payload of the head are held stable until granted.
- Reset:
  - Pointers, count, wait_cnt, tx_count, starve_flag = 0.
  - FSM = IDLE; core_ready = 1; inj_bit = 0; inject_flit = 0.
  - A reset mid-request drops all buffered flits; no partial flit is emitted after reset.
- injection_status while inj_bit = 0 is ignored: no pop, no counter change.

Decomposition:
- Shared package holds:
  - flit field offsets and widths (VALID_BIT, DST_MSB/LSB, SRC_MSB/LSB, AGE_MSB/LSB, PAYLOAD_MSB/LSB);
  - the FLIT_W = 32 constant;
  - the FSM state encoding.
- Sub-module ni_fifo: a synchronous FIFO of 20-bit entries ({dst,payload}) with push/pop/full/empty/count.
- The FSM, wait counter, flit formatter and tx counter stay in the top module.

Test Plan:
- Reset then idle: after rst_n = 0 then 1, inj_bit = 0, inject_flit = 0, core_ready = 1, fifo_count = 0, tx_count = 0.
- Single packet, immediate grant:
  - Push dst = 4'hA, payload = 16'h1234 with injection_status held at 1.
  - Next cycle inject_flit = 32'hD0001234 with SRC_ID = 0 and age = 0.
  - One cycle later inj_bit = 0, tx_count = 1.
- Delayed grant: hold injection_status = 0 for 10 cycles after the request, then 1. The age field reads 10 in the grant cycle, then the flit is popped and wait_cnt = 0.
- Fill and back-pressure:
  - With DEPTH = 4 and no grant, push 5 packets. core_ready drops after the 4th, the 5th is held by the core, and fifo_count = 4.
  - One grant pops the head; core_ready returns to 1 the next cycle.
- Starvation: with STARVE_LIMIT = 32 and no grant, starve_flag rises after 32 ungranted cycles. The age field saturates at 127 after 127 cycles, and starve_flag clears on grant.
- Reset mid-operation: with 3 entries queued and the request pending, assert rst_n = 0 for one cycle. All outputs return to reset values, and a following grant produces no pop.
